mem_port_arbiter: RTL and testbench

- Shares the single SRAM-like data memory port between two requesters: the MEM-stage load/store path (requester D) and the fetch path (requester I).
- Arbitrates each address phase and holds a granted request stable until accepted.
- Records the owner of every accepted transaction in an in-order tag FIFO, and routes each returning data phase to its owner.
- Supports fetch cancellation on pipeline flush: responses owed to cancelled fetches are absorbed and never forwarded.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter_if.sv | 56 +++++
 rtl/mem_port_arbiter_owner_tag_fifo.sv | 79 +++++++
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 tb/tb_mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_port_arbiter_pkg : shared encodings for the memory port arbiter   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package mem_port_arbiter_pkg;

  localparam logic OWN_D = 1'b0;
  localparam logic OWN_I = 1'b1;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_D = 2'd1,
    LOCK_I = 2'd2
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_port_arbiter_if : requester D, requester I and shared port bundle |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface mem_port_arbiter_if;

  logic        d_req;
  logic        d_wr;
  logic [1:0]  d_size;
  logic [3:0]  d_wstrb;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_addr_ok;
  logic        d_data_ok;
  logic [31:0] d_rdata;

  logic        i_req;
  logic [31:0] i_addr;
  logic        i_cancel;
  logic        i_addr_ok;
  logic        i_data_ok;
  logic [31:0] i_rdata;

  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  // slave: the arbiter itself
  modport slave (
    input  d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata,
    output d_addr_ok, d_data_ok, d_rdata,
    input  i_req, i_addr, i_cancel,
    output i_addr_ok, i_data_ok, i_rdata,
    output bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  // master: the requesters plus the shared memory port
  modport master (
    output d_req, d_wr, d_size, d_wstrb, d_addr, d_wdata,
    input  d_addr_ok, d_data_ok, d_rdata,
    output i_req, i_addr, i_cancel,
    input  i_addr_ok, i_data_ok, i_rdata,
    input  bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_owner_tag_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | owner_tag_fifo : in-order {owner, discard} tags of accepted requests  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module owner_tag_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push_i,
  input  logic           push_owner_i,
  input  logic           push_discard_i,
  input  logic           pop_i,
  input  logic           cancel_all_i_i,
  output logic           head_owner_o,
  output logic           head_discard_o,
  output logic           full_o,
  output logic           empty_o,
  output logic [PTR_W:0] count_o
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [DEPTH-1:0] owner_q;
  logic [DEPTH-1:0] disc_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      owner_q  <= '0;
      disc_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // Stale slots may be marked too; a later push overwrites them anyway.
      for (int e = 0; e < DEPTH; e++) begin
        if (push_i && (wr_ptr_q == PTR_W'(e))) begin
          owner_q[e] <= push_owner_i;
          disc_q[e]  <= push_discard_i;
        end else if (cancel_all_i_i && (owner_q[e] == OWN_I)) begin
          disc_q[e]  <= 1'b1;
        end
      end
    end
  end

  assign head_owner_o   = owner_q[rd_ptr_q];
  assign head_discard_o = disc_q[rd_ptr_q] | (cancel_all_i_i & (owner_q[rd_ptr_q] == OWN_I));
  assign full_o         = (count_q == CNT_FULL);
  assign empty_o        = (count_q == '0);
  assign count_o        = count_q;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mem_port_arbiter : shares one SRAM-like port between MEM (D) and      |
// | fetch (I), with in-order response routing and fetch cancellation.     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter  int MAX_OUTSTANDING = 4,
  localparam int PTR_W           = $clog2(MAX_OUTSTANDING)
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  arb_state_e     state_q, state_d;
  logic           lock_cancel_q, lock_cancel_d;
  logic           proto_err_q;
  logic           gnt_d, gnt_i, hs, pop, can_issue, push_discard;
  logic           head_owner, head_discard, full, empty;
  logic [PTR_W:0] count;

  assign pop       = bus.bus_data_ok & ~empty & reset;
  // A pop in this cycle frees a slot for a push in the same cycle.
  assign can_issue = ~full | pop;

  always_comb begin
    gnt_d = 1'b0;
    gnt_i = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (can_issue) begin
          if (bus.d_req)      gnt_d = 1'b1;
          else if (bus.i_req) gnt_i = 1'b1;
        end
      end
      LOCK_D:  gnt_d = 1'b1;
      LOCK_I:  gnt_i = 1'b1;
      default: ;
    endcase
    if (!reset) begin
      gnt_d = 1'b0;
      gnt_i = 1'b0;
    end
  end

  assign hs = (gnt_d | gnt_i) & bus.bus_addr_ok;

  always_comb begin
    state_d = IDLE;
    if ((gnt_d | gnt_i) && !bus.bus_addr_ok) state_d = gnt_d ? LOCK_D : LOCK_I;
    // A fetch stuck in lock when the flush arrives is accepted later but owed nothing.
    lock_cancel_d = gnt_i & ~bus.bus_addr_ok & (lock_cancel_q | bus.i_cancel);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      lock_cancel_q <= 1'b0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      lock_cancel_q <= lock_cancel_d;
      proto_err_q   <= proto_err_q | (bus.bus_data_ok & (count == '0));
    end
  end

  assign push_discard = gnt_i & (bus.i_cancel | lock_cancel_q);

  assign bus.bus_req   = gnt_d | gnt_i;
  assign bus.bus_wr    = gnt_d & bus.d_wr;
  assign bus.bus_size  = gnt_d ? bus.d_size  : SZ_W;
  assign bus.bus_wstrb = gnt_d ? bus.d_wstrb : 4'b0000;
  assign bus.bus_addr  = gnt_d ? bus.d_addr  : bus.i_addr;
  assign bus.bus_wdata = gnt_d ? bus.d_wdata : 32'h0;

  assign bus.d_addr_ok = gnt_d & bus.bus_addr_ok;
  assign bus.i_addr_ok = gnt_i & bus.bus_addr_ok & ~lock_cancel_q;

  assign bus.d_data_ok = pop & (head_owner == OWN_D);
  assign bus.i_data_ok = pop & (head_owner == OWN_I) & ~head_discard;
  assign bus.d_rdata   = bus.bus_rdata;
  assign bus.i_rdata   = bus.bus_rdata;

  owner_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk            (clk),
    .reset          (reset),
    .push_i         (hs),
    .push_owner_i   (gnt_d ? OWN_D : OWN_I),
    .push_discard_i (push_discard),
    .pop_i          (pop),
    .cancel_all_i_i (bus.i_cancel),
    .head_owner_o   (head_owner),
    .head_discard_o (head_discard),
    .full_o         (full),
    .empty_o        (empty),
    .count_o        (count)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mem_port_arbiter : directed self-checking bench for the arbiter    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam logic [31:0] ADDR_A = 32'h1c00_0300;
  localparam logic [31:0] ADDR_B = 32'h1c00_8000;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter_if bif ();

  mem_port_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bif.d_req = 1'b0; bif.d_wr = 1'b0; bif.d_size = SZ_W; bif.d_wstrb = 4'h0;
    bif.d_addr = 32'h0; bif.d_wdata = 32'h0;
    bif.i_req = 1'b0; bif.i_addr = 32'h0; bif.i_cancel = 1'b0;
    bif.bus_addr_ok = 1'b0; bif.bus_data_ok = 1'b0; bif.bus_rdata = 32'h0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    idle_inputs();
    bif.d_req = 1'b1; bif.d_addr = 32'h100; bif.bus_addr_ok = 1'b1; bif.bus_data_ok = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bif.bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b want 0", bif.bus_req); end
    checks++; if (bif.d_addr_ok !== 1'b0) begin errors++; $display("FAIL reset_d_addr_ok: got %b want 0", bif.d_addr_ok); end
    checks++; if (bif.d_data_ok !== 1'b0 || bif.i_data_ok !== 1'b0) begin errors++; $display("FAIL reset_data_ok: got d=%b i=%b want 0 0", bif.d_data_ok, bif.i_data_ok); end
    idle_inputs();
    reset = 1'b1;
    #1;
    checks++; if (dut.u_fifo.count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", dut.u_fifo.count_o); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dut.state_q); end
  endtask

  task automatic test_load_store;
    step();
    bif.d_req = 1'b1; bif.d_wr = 1'b0; bif.d_size = SZ_W; bif.d_addr = 32'h1c00_0100; bif.bus_addr_ok = 1'b1;
    #1;
    checks++; if (bif.bus_req !== 1'b1 || bif.bus_addr !== 32'h1c00_0100) begin errors++; $display("FAIL load_bus: got req=%b addr=%h want 1 1c000100", bif.bus_req, bif.bus_addr); end
    checks++; if (bif.d_addr_ok !== 1'b1 || bif.i_addr_ok !== 1'b0) begin errors++; $display("FAIL load_addr_ok: got d=%b i=%b want 1 0", bif.d_addr_ok, bif.i_addr_ok); end
    step(); idle_inputs(); #1;
    checks++; if (bif.d_data_ok !== 1'b0) begin errors++; $display("FAIL load_early_data: got %b want 0", bif.d_data_ok); end
    step(); bif.bus_data_ok = 1'b1; bif.bus_rdata = 32'hdead_beef; #1;
    checks++; if (bif.d_data_ok !== 1'b1 || bif.d_rdata !== 32'hdead_beef) begin errors++; $display("FAIL load_data: got ok=%b rdata=%h want 1 deadbeef", bif.d_data_ok, bif.d_rdata); end
    checks++; if (bif.i_data_ok !== 1'b0) begin errors++; $display("FAIL load_i_data_ok: got %b want 0", bif.i_data_ok); end
    step(); idle_inputs();
    bif.d_req = 1'b1; bif.d_wr = 1'b1; bif.d_size = SZ_H; bif.d_wstrb = 4'b0011;
    bif.d_addr = 32'h1c00_0204; bif.d_wdata = 32'h0000_abcd; bif.bus_addr_ok = 1'b1;
    #1;
    checks++; if (bif.bus_wstrb !== 4'b0011 || bif.bus_wr !== 1'b1) begin errors++; $display("FAIL store_bus_ctl: got wstrb=%b wr=%b want 0011 1", bif.bus_wstrb, bif.bus_wr); end
    checks++; if (bif.bus_wdata !== 32'h0000_abcd || bif.bus_size !== SZ_H) begin errors++; $display("FAIL store_bus_data: got wdata=%h size=%0d want 0000abcd 1", bif.bus_wdata, bif.bus_size); end
    step(); idle_inputs(); bif.bus_data_ok = 1'b1; #1;
    checks++; if (bif.d_data_ok !== 1'b1 || bif.i_data_ok !== 1'b0) begin errors++; $display("FAIL store_ack: got d=%b i=%b want 1 0", bif.d_data_ok, bif.i_data_ok); end
    step(); idle_inputs();
  endtask

  task automatic test_priority_lock;
    bif.d_req = 1'b1; bif.d_wr = 1'b1; bif.d_wstrb = 4'hf; bif.d_addr = ADDR_A; bif.d_wdata = 32'h1;
    bif.i_req = 1'b1; bif.i_addr = ADDR_B; bif.bus_addr_ok = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bif.bus_addr !== ADDR_A || bif.bus_wstrb !== 4'hf || bif.d_addr_ok !== 1'b0) begin errors++; $display("FAIL prio_hold%0d: got addr=%h wstrb=%h d_ok=%b want %h f 0", c, bif.bus_addr, bif.bus_wstrb, bif.d_addr_ok, ADDR_A); end
      step();
    end
    bif.bus_addr_ok = 1'b1; #1;
    checks++; if (bif.d_addr_ok !== 1'b1 || bif.i_addr_ok !== 1'b0) begin errors++; $display("FAIL prio_accept: got d=%b i=%b want 1 0", bif.d_addr_ok, bif.i_addr_ok); end
    step(); bif.d_req = 1'b0; #1;
    checks++; if (bif.bus_addr !== ADDR_B || bif.i_addr_ok !== 1'b1 || bif.bus_wstrb !== 4'h0) begin errors++; $display("FAIL prio_i_next: got addr=%h i_ok=%b wstrb=%h want %h 1 0", bif.bus_addr, bif.i_addr_ok, bif.bus_wstrb, ADDR_B); end
    step(); idle_inputs(); bif.bus_data_ok = 1'b1; #1;
    checks++; if (bif.d_data_ok !== 1'b1 || bif.i_data_ok !== 1'b0) begin errors++; $display("FAIL prio_resp1: got d=%b i=%b want 1 0", bif.d_data_ok, bif.i_data_ok); end
    step(); #1;
    checks++; if (bif.i_data_ok !== 1'b1 || bif.d_data_ok !== 1'b0) begin errors++; $display("FAIL prio_resp2: got d=%b i=%b want 0 1", bif.d_data_ok, bif.i_data_ok); end
    step(); idle_inputs();
    // fetch locks first, then a D request arrives and must wait
    bif.i_req = 1'b1; bif.i_addr = ADDR_B; #1;
    step(); bif.d_req = 1'b1; bif.d_addr = ADDR_A; #1;
    checks++; if (bif.bus_addr !== ADDR_B || bif.d_addr_ok !== 1'b0) begin errors++; $display("FAIL locki_hold: got addr=%h d_ok=%b want %h 0", bif.bus_addr, bif.d_addr_ok, ADDR_B); end
    step(); bif.bus_addr_ok = 1'b1; #1;
    checks++; if (bif.i_addr_ok !== 1'b1 || bif.d_addr_ok !== 1'b0) begin errors++; $display("FAIL locki_accept: got i=%b d=%b want 1 0", bif.i_addr_ok, bif.d_addr_ok); end
    step(); bif.i_req = 1'b0; #1;
    checks++; if (bif.d_addr_ok !== 1'b1 || bif.bus_addr !== ADDR_A) begin errors++; $display("FAIL locki_d_next: got d_ok=%b addr=%h want 1 %h", bif.d_addr_ok, bif.bus_addr, ADDR_A); end
    step(); idle_inputs(); bif.bus_data_ok = 1'b1; #1;
    checks++; if (bif.i_data_ok !== 1'b1) begin errors++; $display("FAIL locki_resp1: got i=%b want 1", bif.i_data_ok); end
    step(); #1;
    checks++; if (bif.d_data_ok !== 1'b1) begin errors++; $display("FAIL locki_resp2: got d=%b want 1", bif.d_data_ok); end
    step(); idle_inputs();
  endtask

  task automatic test_full;
    bif.i_req = 1'b1; bif.i_addr = 32'h1c00_9000; bif.bus_addr_ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (bif.i_addr_ok !== 1'b1) begin errors++; $display("FAIL full_fill%0d: got %b want 1", c, bif.i_addr_ok); end
      step();
    end
    #1;
    checks++; if (bif.bus_req !== 1'b0 || bif.i_addr_ok !== 1'b0) begin errors++; $display("FAIL full_block: got req=%b i_ok=%b want 0 0", bif.bus_req, bif.i_addr_ok); end
    checks++; if (dut.u_fifo.count_o !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", dut.u_fifo.count_o); end
    step(); bif.bus_data_ok = 1'b1; bif.bus_rdata = 32'h0bad_f00d; #1;
    checks++; if (bif.bus_req !== 1'b1 || bif.i_addr_ok !== 1'b1) begin errors++; $display("FAIL full_reissue: got req=%b i_ok=%b want 1 1", bif.bus_req, bif.i_addr_ok); end
    checks++; if (bif.i_data_ok !== 1'b1 || bif.i_rdata !== 32'h0bad_f00d) begin errors++; $display("FAIL full_pop: got ok=%b rdata=%h want 1 0badf00d", bif.i_data_ok, bif.i_rdata); end
    step(); idle_inputs(); #1;
    checks++; if (dut.u_fifo.count_o !== 3'd4) begin errors++; $display("FAIL full_count_same: got %0d want 4", dut.u_fifo.count_o); end
    bif.bus_data_ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (bif.i_data_ok !== 1'b1) begin errors++; $display("FAIL full_drain%0d: got %b want 1", c, bif.i_data_ok); end
      step();
    end
    idle_inputs(); #1;
    checks++; if (dut.u_fifo.count_o !== 3'd0) begin errors++; $display("FAIL full_empty: got %0d want 0", dut.u_fifo.count_o); end
    step();
  endtask

  task automatic test_cancel;
    bif.i_req = 1'b1; bif.i_addr = 32'h1c00_a000; bif.bus_addr_ok = 1'b1;
    repeat (3) step();
    idle_inputs(); bif.i_cancel = 1'b1;
    step(); idle_inputs();
    bif.d_req = 1'b1; bif.d_addr = ADDR_A; bif.bus_addr_ok = 1'b1; #1;
    checks++; if (bif.d_addr_ok !== 1'b1) begin errors++; $display("FAIL cancel_d_accept: got %b want 1", bif.d_addr_ok); end
    step(); idle_inputs(); bif.bus_data_ok = 1'b1; bif.bus_rdata = 32'h5555_aaaa;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bif.i_data_ok !== 1'b0 || bif.d_data_ok !== 1'b0) begin errors++; $display("FAIL cancel_absorb%0d: got i=%b d=%b want 0 0", c, bif.i_data_ok, bif.d_data_ok); end
      step();
    end
    #1;
    checks++; if (bif.d_data_ok !== 1'b1 || bif.d_rdata !== 32'h5555_aaaa) begin errors++; $display("FAIL cancel_d_resp: got ok=%b rdata=%h want 1 5555aaaa", bif.d_data_ok, bif.d_rdata); end
    step(); idle_inputs(); #1;
    checks++; if (dut.u_fifo.count_o !== 3'd0) begin errors++; $display("FAIL cancel_empty: got %0d want 0", dut.u_fifo.count_o); end
  endtask

  task automatic test_cancel_edges;
    // cancel together with the fetch handshake
    bif.i_req = 1'b1; bif.bus_addr_ok = 1'b1; bif.i_cancel = 1'b1;
    step(); idle_inputs(); bif.bus_data_ok = 1'b1; #1;
    checks++; if (bif.i_data_ok !== 1'b0) begin errors++; $display("FAIL edge_push_cancel: got %b want 0", bif.i_data_ok); end
    // cancel together with the fetch head pop
    step(); idle_inputs(); bif.i_req = 1'b1; bif.bus_addr_ok = 1'b1;
    step(); idle_inputs();
    step(); bif.bus_data_ok = 1'b1; bif.i_cancel = 1'b1; #1;
    checks++; if (bif.i_data_ok !== 1'b0) begin errors++; $display("FAIL edge_pop_cancel: got %b want 0", bif.i_data_ok); end
    // cancel while the fetch is held in lock
    step(); idle_inputs(); bif.i_req = 1'b1; bif.i_addr = ADDR_B;
    step(); bif.i_cancel = 1'b1;
    step(); bif.i_cancel = 1'b0; bif.bus_addr_ok = 1'b1; #1;
    checks++; if (bif.bus_req !== 1'b1 || bif.bus_addr !== ADDR_B || bif.i_addr_ok !== 1'b0) begin errors++; $display("FAIL edge_lock_cancel: got req=%b addr=%h i_ok=%b want 1 %h 0", bif.bus_req, bif.bus_addr, bif.i_addr_ok, ADDR_B); end
    step(); idle_inputs(); bif.bus_data_ok = 1'b1; #1;
    checks++; if (bif.i_data_ok !== 1'b0) begin errors++; $display("FAIL edge_lock_resp: got %b want 0", bif.i_data_ok); end
    step(); idle_inputs(); #1;
    checks++; if (dut.u_fifo.count_o !== 3'd0) begin errors++; $display("FAIL edge_empty: got %0d want 0", dut.u_fifo.count_o); end
  endtask

  task automatic test_protocol_error;
    bif.bus_data_ok = 1'b1; #1;
    checks++; if (bif.d_data_ok !== 1'b0 || bif.i_data_ok !== 1'b0) begin errors++; $display("FAIL proto_no_ok: got d=%b i=%b want 0 0", bif.d_data_ok, bif.i_data_ok); end
    step(); idle_inputs(); #1;
    checks++; if (dut.proto_err_q !== 1'b1) begin errors++; $display("FAIL proto_flag: got %b want 1", dut.proto_err_q); end
    checks++; if (dut.u_fifo.count_o !== 3'd0) begin errors++; $display("FAIL proto_count: got %0d want 0", dut.u_fifo.count_o); end
  endtask

  task automatic test_reset_mid;
    step();
    bif.d_req = 1'b1; bif.d_addr = ADDR_A; bif.bus_addr_ok = 1'b1;
    step(); step();
    bif.bus_addr_ok = 1'b0;
    step(); #1;
    checks++; if (dut.state_q !== LOCK_D || bif.bus_req !== 1'b1) begin errors++; $display("FAIL mid_lock: got state=%0d req=%b want LOCK_D 1", dut.state_q, bif.bus_req); end
    checks++; if (dut.u_fifo.count_o !== 3'd2) begin errors++; $display("FAIL mid_count: got %0d want 2", dut.u_fifo.count_o); end
    #2;
    reset = 1'b0; bif.bus_addr_ok = 1'b1; bif.bus_data_ok = 1'b1;
    #1;
    checks++; if (bif.bus_req !== 1'b0 || bif.d_addr_ok !== 1'b0 || bif.d_data_ok !== 1'b0) begin errors++; $display("FAIL mid_outputs: got req=%b d_addr_ok=%b d_data_ok=%b want 0 0 0", bif.bus_req, bif.d_addr_ok, bif.d_data_ok); end
    checks++; if (dut.u_fifo.count_o !== 3'd0 || dut.state_q !== IDLE) begin errors++; $display("FAIL mid_async_clear: got count=%0d state=%0d want 0 IDLE", dut.u_fifo.count_o, dut.state_q); end
    step(); idle_inputs(); reset = 1'b1; #1;
    checks++; if (dut.u_fifo.count_o !== 3'd0 || dut.state_q !== IDLE || bif.bus_req !== 1'b0) begin errors++; $display("FAIL mid_release: got count=%0d state=%0d req=%b want 0 IDLE 0", dut.u_fifo.count_o, dut.state_q, bif.bus_req); end
  endtask

  initial begin
    test_reset();
    test_load_store();
    test_priority_lock();
    test_full();
    test_cancel();
    test_cancel_edges();
    test_protocol_error();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want normal finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
